// File: rtl/tile_pkg.sv
// Shared constants and map-entry field layout for the tile background renderer.
// Field positions depend only on the tileset geometry, so they are exposed as functions of it.
package tile_pkg;

  localparam int LATENCY = 3;
  localparam logic [11:0] KEY_COLOR_DEFAULT = 12'h00f;

  // Map entry layout: [col | row | x_flip | y_flip | enable], col at bit 0.
  function automatic int f_row_lsb(input int col_bits);
    return col_bits;
  endfunction

  function automatic int f_xflip_bit(input int col_bits, input int row_bits);
    return col_bits + row_bits;
  endfunction

  function automatic int f_yflip_bit(input int col_bits, input int row_bits);
    return col_bits + row_bits + 1;
  endfunction

  function automatic int f_enable_bit(input int col_bits, input int row_bits);
    return col_bits + row_bits + 2;
  endfunction

endpackage

// File: rtl/scroll_shadow_regs.sv
// Pending/active scroll register pair; pending is written any time, active
// only follows it at frame start so a frame is never drawn with mixed scroll.
module scroll_shadow_regs #(
  parameter int SXW = 10,
  parameter int SYW = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           scroll_we,
  input  logic [SXW-1:0] scroll_x_in,
  input  logic [SYW-1:0] scroll_y_in,
  output logic [SXW-1:0] active_x,
  output logic [SYW-1:0] active_y
);

  logic [SXW-1:0] pending_x_reg, active_x_reg;
  logic [SYW-1:0] pending_y_reg, active_y_reg;

  // A write coinciding with frame_start lands in pending only; active
  // captures the value pending held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_x_reg <= '0;
      pending_y_reg <= '0;
      active_x_reg  <= '0;
      active_y_reg  <= '0;
    end else begin
      if (frame_start) begin
        active_x_reg <= pending_x_reg;
        active_y_reg <= pending_y_reg;
      end
      if (scroll_we) begin
        pending_x_reg <= scroll_x_in;
        pending_y_reg <= scroll_y_in;
      end
    end
  end

  assign active_x = active_x_reg;
  assign active_y = active_y_reg;

endmodule

// File: rtl/tile_scroll_engine.sv
// Pipelined tile-map background renderer: raster coordinate -> map RAM -> tileset ROM
// -> registered pixel, fixed three-cycle latency, wrapping X/Y scroll below a static band.
module tile_scroll_engine
  import tile_pkg::*;
#(
  parameter int TILE_W    = 16,
  parameter int TILE_H    = 16,
  parameter int MAP_COLS  = 64,
  parameter int MAP_ROWS  = 32,
  parameter int TSET_COLS = 8,
  parameter int TSET_ROWS = 8,
  parameter int SPLIT_Y   = 101,
  parameter int COLOR_W   = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(KEY_COLOR_DEFAULT),
  localparam int SXW = $clog2(MAP_COLS * TILE_W),
  localparam int SYW = $clog2(MAP_ROWS * TILE_H),
  localparam int AW  = $clog2(MAP_COLS * MAP_ROWS),
  localparam int RXW = $clog2(TSET_COLS * TILE_W),
  localparam int RYW = $clog2(TSET_ROWS * TILE_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               frame_start,
  input  logic               scroll_we,
  input  logic [SXW-1:0]     scroll_x_in,
  input  logic [SYW-1:0]     scroll_y_in,
  output logic [AW-1:0]      ram_addr,
  input  logic [15:0]        ram_data,
  output logic [RXW-1:0]     rom_x,
  output logic [RYW-1:0]     rom_y,
  input  logic [COLOR_W-1:0] rom_data,
  output logic               pixel_on,
  output logic [COLOR_W-1:0] color
);

  localparam int TWB     = $clog2(TILE_W);
  localparam int THB     = $clog2(TILE_H);
  localparam int CB      = $clog2(TSET_COLS);
  localparam int RB      = $clog2(TSET_ROWS);
  localparam int ROW_LSB = f_row_lsb(CB);
  localparam int XF_BIT  = f_xflip_bit(CB, RB);
  localparam int YF_BIT  = f_yflip_bit(CB, RB);
  localparam int EN_BIT  = f_enable_bit(CB, RB);
  localparam logic [9:0] SPLIT_Y_V = 10'(SPLIT_Y);

  logic [SXW-1:0] active_x;
  logic [SYW-1:0] active_y;

  scroll_shadow_regs #(
    .SXW(SXW),
    .SYW(SYW)
  ) u_shadow (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .scroll_we  (scroll_we),
    .scroll_x_in(scroll_x_in),
    .scroll_y_in(scroll_y_in),
    .active_x   (active_x),
    .active_y   (active_y)
  );

  // Stage 0: effective map coordinate; the wrap is plain truncation to register width.
  logic [SXW-1:0] px;
  logic [SYW-1:0] py;

  always_comb begin
    px = SXW'(x);
    py = SYW'(y);
    if (y >= SPLIT_Y_V) begin
      px = SXW'(x) + active_x;
      py = SYW'(y) + active_y;
    end
  end

  assign ram_addr = {py[SYW-1:THB], px[SXW-1:TWB]};

  logic [TWB-1:0] fx_reg;
  logic [THB-1:0] fy_reg;
  logic           von1_reg;
  logic           en2_reg, von2_reg;
  logic           pixel_on_reg;
  logic [COLOR_W-1:0] color_reg;

  // Stage 1: tileset address. Inverting every bit of a power-of-two offset
  // gives TILE-1-offset, so each flip is a per-bit XOR.
  logic           x_flip, y_flip, tile_en;
  logic [TWB-1:0] fx_eff;
  logic [THB-1:0] fy_eff;
  logic           unused_ram_bits;

  assign x_flip  = ram_data[XF_BIT];
  assign y_flip  = ram_data[YF_BIT];
  assign tile_en = ram_data[EN_BIT];
  assign unused_ram_bits = ^ram_data;

  genvar gi;
  generate
    for (gi = 0; gi < TWB; gi++) begin : g_fx
      assign fx_eff[gi] = fx_reg[gi] ^ x_flip;
    end
    for (gi = 0; gi < THB; gi++) begin : g_fy
      assign fy_eff[gi] = fy_reg[gi] ^ y_flip;
    end
  endgenerate

  assign rom_x = {ram_data[CB-1:0], fx_eff};
  assign rom_y = {ram_data[ROW_LSB +: RB], fy_eff};

  // Stage 2 -> 3: key test on the ROM pixel.
  logic               pixel_on_next;
  logic [COLOR_W-1:0] color_next;

  always_comb begin
    pixel_on_next = von2_reg & en2_reg & (rom_data != KEY_COLOR);
    color_next    = pixel_on_next ? rom_data : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fx_reg       <= '0;
      fy_reg       <= '0;
      von1_reg     <= 1'b0;
      en2_reg      <= 1'b0;
      von2_reg     <= 1'b0;
      pixel_on_reg <= 1'b0;
      color_reg    <= '0;
    end else begin
      fx_reg       <= px[TWB-1:0];
      fy_reg       <= py[THB-1:0];
      von1_reg     <= video_on;
      en2_reg      <= tile_en;
      von2_reg     <= von1_reg;
      pixel_on_reg <= pixel_on_next;
      color_reg    <= color_next;
    end
  end

  assign pixel_on = pixel_on_reg;
  assign color    = color_reg;

endmodule

// File: doc/tile_scroll_engine.md
# tile_scroll_engine

Pipelined, parametrised tile-map background renderer for the VGA pixel path, replacing the fixed 640×480 / 16×16 combinational engine. It converts the current raster coordinate into a tile-map RAM read and a tileset ROM read. It supports independent X and Y scrolling over a wrapping map larger than the screen, with a non-scrolling status band at the top of the screen. Scroll values are double-buffered and applied only at frame start, so the image does not tear. Output goes to the sprite/background mixer with a fixed 3-cycle latency.

## Interface
Parameters:
- TILE_W, 16: tile width in pixels; power of two.
- TILE_H, 16: tile height in pixels; power of two.
- MAP_COLS, 64: tile-map columns; power of two.
- MAP_ROWS, 32: tile-map rows; power of two.
- TSET_COLS, 8: tileset columns in ROM; power of two.
- TSET_ROWS, 8: tileset rows in ROM; power of two.
- SPLIT_Y, 101: rows with y < SPLIT_Y ignore scroll.
- COLOR_W, 12: color width.
- KEY_COLOR, 12'h00f: transparent key color.

Ports:
- clk  in  1: pixel clock; the block has one clock.
- reset  in  1: asynchronous, active-high.
- video_on  in  1: (x,y) is in the visible area.
- x, y  in  10 each: raster coordinate.
- frame_start  in  1: one-cycle pulse at the start of vertical blank.
- scroll_we  in  1: write enable for the pending scroll registers.
- scroll_x_in  in  log2(MAP_COLS·TILE_W): pending X scroll.
- scroll_y_in  in  log2(MAP_ROWS·TILE_H): pending Y scroll.
- ram_addr  out  log2(MAP_COLS·MAP_ROWS): tile-map RAM address.
- ram_data  in  16: map entry; synchronous RAM, 1-cycle read latency.
- rom_x  out  log2(TSET_COLS·TILE_W): tileset pixel column.
- rom_y  out  log2(TSET_ROWS·TILE_H): tileset pixel row.
- rom_data  in  COLOR_W: tileset pixel; synchronous ROM, 1-cycle read latency.
- pixel_on  out  1: background pixel is opaque.
- color  out  COLOR_W: pixel color; 0 when pixel_on is 0.

## Operation
Map entry fields (C = log2 TSET_COLS, R = log2 TSET_ROWS):
- tile_col = [C-1:0]
- tile_row = [C+R-1:C]
- x_flip = [C+R]
- y_flip = [C+R+1]
- enable = [C+R+2]
- Remaining bits are ignored.

Scroll registers:
- Two pending registers and two active registers, all reset to 0.
- scroll_we loads the pending registers.
- frame_start copies pending to active.
- If scroll_we and frame_start occur in the same cycle: active takes the old pending value; the new value lands in pending and is applied at the next frame_start.

Coordinate mapping:
- Static band (y < SPLIT_Y): effective coordinate is (px, py) = (x, y).
- Otherwise: px = (x + active_x) mod (MAP_COLS·TILE_W), py = (y + active_y) mod (MAP_ROWS·TILE_H). The wrap is done by truncation to the register width, with no carry out.
- ram_addr = (py / TILE_H)·MAP_COLS + (px / TILE_W). It is combinational from x, y and the active registers.
- fx = px mod TILE_W, fy = py mod TILE_H. Both are carried forward one pipeline stage, together with video_on.

Tileset lookup:
- rom_x = tile_col·TILE_W + (x_flip ? TILE_W-1-fx : fx).
- rom_y = tile_row·TILE_H + (y_flip ? TILE_H-1-fy : fy).
- Both are combinational from ram_data and the stage-1 registers.
- enable and video_on are carried one further stage.

Output:
- pixel_on = video_on & enable & (rom_data != KEY_COLOR).
- color = pixel_on ? rom_data : 0.
- Both are registered.

## Timing
- Cycle 0: x, y, video_on presented; ram_addr valid.
- Cycle 1: ram_data valid; rom_x and rom_y valid.
- Cycle 2: rom_data valid.
- Cycle 3: pixel_on and color registered out. Fixed latency LATENCY = 3; the timing generator offsets its coordinates by 3.
- Fully pipelined: one pixel per clock, no stalls, no handshake.
- Reset (asynchronous, any time including mid-line): all pipeline registers, scroll registers, pixel_on and color go to 0. The first valid output appears 3 cycles after reset deasserts.
- A new active scroll value takes effect on pixels whose cycle-0 falls after the frame_start cycle.

## Structure
- Shared package tile_pkg holds:
  - map entry field positions, derived from TSET_COLS/TSET_ROWS;
  - LATENCY = 3;
  - KEY_COLOR default.
- One sub-module, scroll_shadow_regs: the pending/active register pair plus the frame_start/scroll_we priority logic.
- The pipeline, address arithmetic and flip logic stay in the top module.

## Test plan
- Reset, default parameters, y=0, video_on=1, ram_data entry col=2,row=1,no flip,enable=1, x=5 → ram_addr=0, rom_x=37, rom_y=16; pixel_on asserts 3 cycles after x is presented.
- scroll_we with scroll_x=1020, no frame_start, y=200, x=10 → ram_addr=12·64+0=768 (scroll unchanged). After frame_start, same x,y → ram_addr=768+((10+1020) mod 1024)/16=768; fx=6.
- Static band: active scroll_x=100, scroll_y=16, y=50, x=40 → ram_addr=3·64+2=194 (scroll ignored); at y=101 → ram_addr=7·64+8=456.
- x_flip=1, y_flip=1, col=0,row=0, fx=3, fy=4 → rom_x=12, rom_y=11.
- rom_data=12'h00f or enable=0 or video_on=0 → pixel_on=0, color=0. rom_data=12'h0a5, enable=1, video_on=1 → color=12'h0a5.
- scroll_we and frame_start in the same cycle (pending 5, new 9) → active=5; after the next frame_start, active=9. Assert reset mid-line → outputs 0 immediately; no stale pixel after release.
